// File: rtl/hamming_encoder_stream.sv
// Byte-stream Hamming(7,4) encoder: low nibble then high nibble, registered valid/ready
// output, one-shot single-bit error injection and a wrapping codeword counter.
module hamming_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk_enc,
  input  logic             rst_enc,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:7]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             inj_arm,
  input  logic [2:0]       inj_pos,
  output logic             inj_pending,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:7]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic [2:0]       ipos_q, ipos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic [3:0]       nib;
  logic [1:7]       flip_mask;

  // Codeword order p1 p2 d1 p4 d2 d3 d4, with d1 the nibble MSB.
  function automatic logic [1:7] enc(input logic [3:0] n);
    logic d1, d2, d3, d4;
    d1 = n[3];
    d2 = n[2];
    d3 = n[1];
    d4 = n[0];
    return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
  endfunction

  always_comb begin
    flip_mask = '0;
    for (int i = 1; i <= 7; i++) flip_mask[i] = (ipos_q == 3'(i));
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      HI:      in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (!rst_enc) in_ready = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    load    = 1'b0;
    nib     = in_byte[3:0];
    case (state_q)
      IDLE: if (in_valid) begin
        byte_d  = in_byte;
        load    = 1'b1;
        state_d = LO;
      end
      LO: if (out_ready) begin
        load    = 1'b1;
        nib     = byte_q[7:4];
        state_d = HI;
      end
      HI: if (out_ready) begin
        if (in_valid) begin
          byte_d  = in_byte;
          load    = 1'b1;
          state_d = LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d != IDLE);

    // An arm in the same cycle as a load only affects the following load.
    pend_d = pend_q;
    ipos_d = ipos_q;
    code_d = code_q;
    if (load) code_d = enc(nib);
    if (inj_arm) begin
      pend_d = (inj_pos != 3'd0);
      ipos_d = inj_pos;
    end else if (load && pend_q) begin
      code_d = enc(nib) ^ flip_mask;
      pend_d = 1'b0;
      ipos_d = 3'd0;
    end

    cnt_d = cnt_q;
    if (valid_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_enc) begin
    if (!rst_enc) begin
      state_q <= IDLE;
      byte_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      ipos_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ipos_q  <= ipos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_code    = code_q;
  assign out_valid   = valid_q;
  assign inj_pending = pend_q;
  assign cw_count    = cnt_q;

endmodule

// File: doc/hamming_encoder_stream.md
Name: hamming_encoder_stream

Overview:
- Upstream stage of hamming_decoder. Accepts a byte stream over a valid/ready handshake.
- Splits each byte into two nibbles, low nibble first, and Hamming(7,4)-encodes each one.
- Presents each 7-bit codeword on a registered valid/ready output that feeds the decoder's dec_data.
- Includes a one-shot single-bit error-injection hook and a codeword counter for link bring-up.

Parameters:
- CNT_W, 16, width of the emitted-codeword counter.

Ports:
- clk_enc  input  1  clock; all logic rises on posedge.
- rst_enc  input  1  synchronous active-low reset.
- in_byte  input  8  data byte; sampled when in_valid && in_ready.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  encoder can accept a byte this cycle.
- out_code  output  [1:7]  codeword, position 1 is MSB: p1 p2 d1 p4 d2 d3 d4.
- out_valid  output  1  out_code holds a valid codeword.
- out_ready  input  1  downstream accepts out_code this cycle.
- inj_arm  input  1  one-cycle pulse; arms injection at position inj_pos.
- inj_pos  input  3  bit position to flip, 1..7; 0 means no flip.
- inj_pending  output  1  injection armed, not yet applied.
- cw_count  output  CNT_W  count of codewords transferred; wraps.

Behaviour:
- Encoding:
  - Nibble maps to d1..d4 with d1 = nibble[3] (MSB) and d4 = nibble[0].
  - p1 = d1^d2^d4, p2 = d1^d3^d4, p4 = d2^d3^d4.
  - The decoder recovers data from positions 3, 5, 6, 7.
- Reset (rst_enc==0 at posedge):
  - state=IDLE, out_code=0, out_valid=0, inj_pending=0, stored inj position=0, cw_count=0, byte register=0.
  - in_ready is forced 0 while rst_enc is low.
  - Reset mid-transfer drops the held byte and any pending injection.
- FSM, with out_valid=1 exactly in LO and HI:
  - IDLE: in_ready=1. On in_valid: latch byte; out_code <= enc(byte[3:0]); go LO.
  - LO: in_ready=0. On out_ready: out_code <= enc(byte[7:4]); go HI. Otherwise hold out_code stable.
  - HI: in_ready=out_ready.
    - out_ready && in_valid: latch new byte; out_code <= enc(new[3:0]); go LO.
    - out_ready && !in_valid: out_valid <= 0; go IDLE.
    - !out_ready: hold.
- Latency and throughput:
  - First codeword is valid one cycle after byte acceptance.
  - Sustained rate is 1 byte per 2 cycles with zero bubbles when in_valid and out_ready are held high.
- Handshake rules:
  - out_code and out_valid never change while out_valid && !out_ready.
  - in_ready never depends on in_valid.
- Injection:
  - inj_arm with inj_pos!=0 sets inj_pending and stores inj_pos. Arming while pending overwrites the position.
  - inj_arm with inj_pos==0 clears pending.
  - The next out_code load in a later cycle is XORed with a one-hot at the stored position, then inj_pending clears.
  - If inj_arm coincides with a load, that load is unmodified and the injection applies to the following load.
- cw_count:
  - Increments by 1 on each out_valid && out_ready cycle.
  - Wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then in_byte=0xB4 with in_valid=1 and out_ready=1 → out_code=0x4C (cycle+1), 0x33 (cycle+2); cw_count=2; in_ready=1 in IDLE.
- Bytes 0x00, 0xFF, 0xB4 back-to-back with out_ready=1 → codewords 0x00, 0x00, 0x7F, 0x7F, 0x4C, 0x33 with no gaps; in_ready high every 2nd cycle.
- Backpressure: out_ready=0 for 5 cycles while in LO with 0x4C → out_code stays 0x4C, out_valid stays 1, in_ready=0, cw_count unchanged.
- inj_arm with inj_pos=3, then byte 0xB4 → first codeword 0x5C, second 0x33; inj_pending 1→0 on the load.
- Assert rst_enc=0 while in HI → next cycle out_valid=0, cw_count=0, inj_pending=0; after release, byte 0x0F → codewords 0x7F, 0x00.
- CNT_W=2, transfer 5 codewords → cw_count sequence 1, 2, 3, 0, 1.
